// File: rtl/tcb_cmd_pkg.sv
// Shared types and helpers for the TCB command manager.
// Data-width dependent structs live in the top module because packages cannot be parameterized.
package tcb_cmd_pkg;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC
   } cntOp_e;

   function automatic bit isPow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB bus interface: manager drives the request, subordinate returns ready, read data and error.
interface tcb_if #(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned DLY = 1
) (
   input logic clk,
   input logic rst
);

   logic            vld;
   logic            wen;
   logic [AW-1:0]   adr;
   logic [DW/8-1:0] ben;
   logic [DW-1:0]   wdt;
   logic            rdy;
   logic [DW-1:0]   rdt;
   logic            err;

   modport man (
      input  clk, rst,
      output vld, wen, adr, ben, wdt,
      input  rdy, rdt, err
   );

   modport sub (
      input  clk, rst,
      input  vld, wen, adr, ben, wdt,
      output rdy, rdt, err
   );

endinterface

// File: rtl/tcb_rsp_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry reads as zero while empty.
module tcb_rsp_fifo
   import tcb_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  T     pushData_i,
   input  logic pop_i,
   output T     popData_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = $clog2(DEPTH) + 1;

   if (!isPow2(DEPTH)) begin : gDepthErr
      $error("tcb_rsp_fifo: DEPTH must be a power of 2");
   end

   T              mem [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [IW-1:0] wIdx, rIdx;
   logic          doPush, doPop;

   // Pointers count modulo 2*DEPTH so the extra bit separates full from empty.
   assign wIdx    = IW'(wptr_q % PW'(DEPTH));
   assign rIdx    = IW'(rptr_q % PW'(DEPTH));
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = ((wptr_q - rptr_q) == PW'(DEPTH));
   assign doPush  = push_i & ~full_o;
   assign doPop   = pop_i & ~empty_o;
   assign wptr_d  = wptr_q + PW'(doPush);
   assign rptr_d  = rptr_q + PW'(doPop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem[wIdx] <= pushData_i;
      end
   end

   assign popData_o = empty_o ? '0 : mem[rIdx];

endmodule

// File: rtl/tcb_cmd_man.sv
// TCB manager: turns a valid/ready command stream into TCB transfers and returns
// one in-order response per transfer, throttled by a response credit counter.
module tcb_cmd_man
   import tcb_cmd_pkg::*;
#(
   parameter int unsigned DLY       = 1,
   parameter int unsigned RSP_DEPTH = 4
) (
   tcb_if.man                 bus,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic               cmd_wen,
   input  logic [bus.AW-1:0]  cmd_adr,
   input  logic [bus.DW/8-1:0] cmd_ben,
   input  logic [bus.DW-1:0]  cmd_wdt,
   output logic               rsp_vld,
   input  logic               rsp_rdy,
   output logic               rsp_wen,
   output logic [bus.DW-1:0]  rsp_rdt,
   output logic               rsp_err,
   output logic               busy
);

   localparam int unsigned AW = bus.AW;
   localparam int unsigned DW = bus.DW;
   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic            wen;
      logic [AW-1:0]   adr;
      logic [DW/8-1:0] ben;
      logic [DW-1:0]   wdt;
   } cmd_t;

   typedef struct packed {
      logic          wen;
      logic [DW-1:0] rdt;
      logic          err;
   } rsp_t;

   if (DLY != bus.DLY) begin : gDlyErr
      $error("tcb_cmd_man: DLY does not match bus.DLY");
   end
   if (!isPow2(RSP_DEPTH)) begin : gDepthErr
      $error("tcb_cmd_man: RSP_DEPTH must be a power of 2");
   end
   if ((DW % 8) != 0) begin : gDwErr
      $error("tcb_cmd_man: bus.DW must be a multiple of 8");
   end

   cmd_t          cmd;
   logic          credit;
   logic          trn;
   logic          pop;
   logic [CW-1:0] cnt_q, cnt_d;
   cntOp_e        cntOp;
   logic          capVld;
   logic          capWen;
   rsp_t          capRsp;
   rsp_t          rspHead;
   logic          rspFull;
   logic          rspEmpty;

   // A command may only start when its response is guaranteed a buffer slot.
   assign credit  = (cnt_q < CW'(RSP_DEPTH)) & ~bus.rst;
   assign cmd     = '{wen: cmd_wen, adr: cmd_adr, ben: cmd_ben, wdt: cmd_wdt};
   assign bus.vld = cmd_vld & credit;
   assign bus.wen = cmd.wen;
   assign bus.adr = cmd.adr;
   assign bus.ben = cmd.ben;
   assign bus.wdt = cmd.wdt;
   assign cmd_rdy = bus.rdy & credit;
   assign trn     = bus.vld & bus.rdy;
   assign pop     = rsp_vld & rsp_rdy;
   assign busy    = (cnt_q != '0);

   always_comb begin
      cntOp = CNT_HOLD;
      if (trn && !pop) begin
         cntOp = CNT_INC;
      end else if (!trn && pop) begin
         cntOp = CNT_DEC;
      end
      cnt_d = cnt_q;
      case (cntOp)
         CNT_INC: cnt_d = cnt_q + CW'(1);
         CNT_DEC: cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge bus.clk or posedge bus.rst) begin
      if (bus.rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   if (DLY == 0) begin : gNoDly
      assign capVld = trn;
      assign capWen = cmd_wen;
   end else begin : gDly
      logic [DLY-1:0] pipeVld_q, pipeVld_d;
      logic [DLY-1:0] pipeWen_q, pipeWen_d;

      always_comb begin
         pipeVld_d    = pipeVld_q << 1;
         pipeWen_d    = pipeWen_q << 1;
         pipeVld_d[0] = trn;
         pipeWen_d[0] = cmd_wen;
      end

      always_ff @(posedge bus.clk or posedge bus.rst) begin
         if (bus.rst) begin
            pipeVld_q <= '0;
            pipeWen_q <= '0;
         end else begin
            pipeVld_q <= pipeVld_d;
            pipeWen_q <= pipeWen_d;
         end
      end

      assign capVld = pipeVld_q[DLY-1];
      assign capWen = pipeWen_q[DLY-1];
   end

   assign capRsp = '{wen: capWen, rdt: bus.rdt, err: bus.err};

   tcb_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_t)
   ) uRspFifo (
      .clk_i      (bus.clk),
      .rst_i      (bus.rst),
      .push_i     (capVld),
      .pushData_i (capRsp),
      .pop_i      (pop),
      .popData_o  (rspHead),
      .full_o     (rspFull),
      .empty_o    (rspEmpty)
   );

   assign rsp_vld = ~rspEmpty;
   assign rsp_wen = rspHead.wen;
   assign rsp_rdt = rspHead.rdt;
   assign rsp_err = rspHead.err;

   // The credit counter makes a push into a full buffer unreachable.
   assert property (@(posedge bus.clk) disable iff (bus.rst) !(capVld && rspFull));

endmodule

// File: tb/tb_tcb_cmd_man.sv
// Self-checking bench for tcb_cmd_man with a DLY=1 memory subordinate that errors on address 0x0C.
module tb_tcb_cmd_man;

   localparam int unsigned AW        = 8;
   localparam int unsigned DW        = 32;
   localparam int unsigned DLY       = 1;
   localparam int unsigned RSP_DEPTH = 4;
   localparam int          NVEC      = 16;

   typedef struct {
      logic          wen;
      logic [AW-1:0] adr;
      logic [3:0]    ben;
      logic [DW-1:0] wdt;
      logic [DW-1:0] expRdt;
      logic          expErr;
   } vec_t;

   typedef struct {
      logic          wen;
      logic [DW-1:0] rdt;
      logic          err;
   } rspRec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          cmd_vld, cmd_rdy, cmd_wen;
   logic [AW-1:0] cmd_adr;
   logic [3:0]    cmd_ben;
   logic [DW-1:0] cmd_wdt;
   logic          rsp_vld, rsp_rdy, rsp_wen, rsp_err, busy;
   logic [DW-1:0] rsp_rdt;

   logic          subRdy;
   logic [DW-1:0] subMem [16];
   logic [DW-1:0] subRdt = '0;
   logic          subErr = 1'b0;

   int        checks   = 0;
   int        failures = 0;
   int        cyc      = 0;
   int        stalls   = 0;
   int        acc      = 0;
   rspRec_t   rspQ [$];
   int        rspCyc [$];
   int        trnCyc [$];
   vec_t      vecs [NVEC];
   logic [AW-1:0] bpAdr [6];
   logic [DW-1:0] bpExp [5];

   always #5 clk = ~clk;

   tcb_if #(.AW(AW), .DW(DW), .DLY(DLY)) bus (.clk(clk), .rst(rst));

   tcb_cmd_man #(.DLY(DLY), .RSP_DEPTH(RSP_DEPTH)) dut (
      .bus     (bus),
      .cmd_vld (cmd_vld),
      .cmd_rdy (cmd_rdy),
      .cmd_wen (cmd_wen),
      .cmd_adr (cmd_adr),
      .cmd_ben (cmd_ben),
      .cmd_wdt (cmd_wdt),
      .rsp_vld (rsp_vld),
      .rsp_rdy (rsp_rdy),
      .rsp_wen (rsp_wen),
      .rsp_rdt (rsp_rdt),
      .rsp_err (rsp_err),
      .busy    (busy)
   );

   // Memory subordinate answering one cycle after each transfer.
   assign bus.rdy = subRdy;
   assign bus.rdt = subRdt;
   assign bus.err = subErr;

   always @(posedge clk) begin
      if (bus.vld && bus.rdy) begin
         if (bus.wen) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.ben[b]) subMem[bus.adr[5:2]][8*b +: 8] <= bus.wdt[8*b +: 8];
            end
         end
         subRdt <= bus.wen ? '0 : subMem[bus.adr[5:2]];
         subErr <= (bus.adr == 8'h0C);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Handshakes are recorded mid-cycle, ahead of the edge that completes them.
   always @(negedge clk) begin
      if (bus.vld && bus.rdy) trnCyc.push_back(cyc);
      if (rsp_vld && rsp_rdy) begin
         rspQ.push_back('{rsp_wen, rsp_rdt, rsp_err});
         rspCyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearMon();
      rspQ.delete();
      rspCyc.delete();
      trnCyc.delete();
   endtask

   // Present one command from posedge+1 and return at posedge+1 after it is accepted.
   task automatic applyStimulus(input vec_t v);
      int waited;
      waited  = 0;
      cmd_vld = 1'b1;
      cmd_wen = v.wen;
      cmd_adr = v.adr;
      cmd_ben = v.ben;
      cmd_wdt = v.wdt;
      @(negedge clk);
      while (!cmd_rdy && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_rdy) checkOutput("cmd_accept_timeout", 64'(0), 64'(1));
      stalls += waited;
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
   endtask

   task automatic pumpCmds(input int n);
      logic hs;
      repeat (n) begin
         cmd_vld = (acc < 6);
         cmd_adr = bpAdr[(acc < 6) ? acc : 5];
         @(negedge clk);
         hs = cmd_vld && cmd_rdy;
         @(posedge clk);
         #1;
         if (hs) acc++;
      end
      cmd_vld = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h00, 4'hF, 32'h0000005A, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 8'h00, 4'hF, 32'h0,        32'h0000005A, 1'b0};
      vecs[2]  = '{1'b1, 8'h04, 4'hF, 32'h11223344, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 8'h08, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0};
      vecs[4]  = '{1'b1, 8'h0C, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1};
      vecs[5]  = '{1'b1, 8'h08, 4'h3, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[6]  = '{1'b1, 8'h10, 4'hF, 32'h0BADF00D, 32'h0,        1'b0};
      vecs[7]  = '{1'b1, 8'h14, 4'hC, 32'h12345678, 32'h0,        1'b0};
      vecs[8]  = '{1'b0, 8'h00, 4'hF, 32'h0,        32'h0000005A, 1'b0};
      vecs[9]  = '{1'b0, 8'h04, 4'hF, 32'h0,        32'h11223344, 1'b0};
      vecs[10] = '{1'b0, 8'h08, 4'hF, 32'h0,        32'hA5A5FFFF, 1'b0};
      vecs[11] = '{1'b0, 8'h0C, 4'hF, 32'h0,        32'hDEADBEEF, 1'b1};
      vecs[12] = '{1'b0, 8'h10, 4'hF, 32'h0,        32'h0BADF00D, 1'b0};
      vecs[13] = '{1'b0, 8'h14, 4'hF, 32'h0,        32'h12340000, 1'b0};
      vecs[14] = '{1'b0, 8'h18, 4'hF, 32'h0,        32'h00000000, 1'b0};
      vecs[15] = '{1'b0, 8'h1C, 4'hF, 32'h0,        32'h00000000, 1'b0};
      bpAdr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
      bpExp = '{32'h0000005A, 32'h11223344, 32'hA5A5FFFF, 32'hDEADBEEF, 32'h0BADF00D};
      for (int i = 0; i < 16; i++) subMem[i] = '0;

      // Reset state with a command already offered.
      rst     = 1'b1;
      subRdy  = 1'b1;
      rsp_rdy = 1'b1;
      cmd_vld = 1'b1;
      cmd_wen = 1'b1;
      cmd_adr = 8'h20;
      cmd_ben = 4'hF;
      cmd_wdt = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cmd_rdy", 64'(cmd_rdy), 64'(0));
      checkOutput("reset_bus_vld", 64'(bus.vld), 64'(0));
      checkOutput("reset_rsp_vld", 64'(rsp_vld), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_rsp_wen", 64'(rsp_wen), 64'(0));
      checkOutput("reset_rsp_rdt", 64'(rsp_rdt), 64'(0));
      checkOutput("reset_rsp_err", 64'(rsp_err), 64'(0));
      cmd_vld = 1'b0;
      rst     = 1'b0;
      waitCycles(1);
      clearMon();

      // Table: streaming writes then reads, consumer always ready.
      for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
      waitCycles(6);
      checkOutput("table_stalls", 64'(stalls), 64'(0));
      checkOutput("table_rsp_count", 64'(rspQ.size()), 64'(NVEC));
      for (int i = 0; i < NVEC; i++) begin
         if (i < rspQ.size() && i < trnCyc.size()) begin
            checkOutput($sformatf("table_wen[%0d]", i), 64'(rspQ[i].wen), 64'(vecs[i].wen));
            checkOutput($sformatf("table_err[%0d]", i), 64'(rspQ[i].err), 64'(vecs[i].expErr));
            if (!vecs[i].wen) checkOutput($sformatf("table_rdt[%0d]", i), 64'(rspQ[i].rdt), 64'(vecs[i].expRdt));
            checkOutput($sformatf("table_latency[%0d]", i), 64'(rspCyc[i] - trnCyc[i]), 64'(DLY + 1));
            if (i > 0) checkOutput($sformatf("table_consecutive[%0d]", i), 64'(rspCyc[i] - rspCyc[i-1]), 64'(1));
         end
      end
      checkOutput("table_idle_busy", 64'(busy), 64'(0));

      // Consumer stalled: only RSP_DEPTH commands get in, then one more per pop.
      clearMon();
      rsp_rdy = 1'b0;
      cmd_wen = 1'b0;
      cmd_ben = 4'hF;
      acc     = 0;
      pumpCmds(10);
      checkOutput("bp_accepted", 64'(acc), 64'(RSP_DEPTH));
      cmd_vld = 1'b1;
      @(negedge clk);
      checkOutput("bp_cmd_rdy", 64'(cmd_rdy), 64'(0));
      checkOutput("bp_busy", 64'(busy), 64'(1));
      checkOutput("bp_rsp_vld", 64'(rsp_vld), 64'(1));
      @(posedge clk);
      #1;
      rsp_rdy = 1'b1;
      pumpCmds(1);
      rsp_rdy = 1'b0;
      pumpCmds(6);
      checkOutput("bp_accepted_after_pop", 64'(acc), 64'(RSP_DEPTH + 1));
      rsp_rdy = 1'b1;
      waitCycles(10);
      checkOutput("bp_rsp_count", 64'(rspQ.size()), 64'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < rspQ.size()) begin
            checkOutput($sformatf("bp_rdt[%0d]", i), 64'(rspQ[i].rdt), 64'(bpExp[i]));
            checkOutput($sformatf("bp_err[%0d]", i), 64'(rspQ[i].err), 64'(i == 3));
         end
      end
      checkOutput("bp_drained_busy", 64'(busy), 64'(0));

      // Subordinate holds off for three cycles.
      clearMon();
      subRdy  = 1'b0;
      cmd_vld = 1'b1;
      cmd_wen = 1'b0;
      cmd_adr = 8'h04;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("stall_bus_vld[%0d]", c), 64'(bus.vld), 64'(1));
         checkOutput($sformatf("stall_bus_adr[%0d]", c), 64'(bus.adr), 64'(8'h04));
         checkOutput($sformatf("stall_cmd_rdy[%0d]", c), 64'(cmd_rdy), 64'(0));
         checkOutput($sformatf("stall_rsp_vld[%0d]", c), 64'(rsp_vld), 64'(0));
         @(posedge clk);
         #1;
      end
      subRdy = 1'b1;
      @(negedge clk);
      checkOutput("stall_release_cmd_rdy", 64'(cmd_rdy), 64'(1));
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
      waitCycles(5);
      checkOutput("stall_trn_count", 64'(trnCyc.size()), 64'(1));
      checkOutput("stall_rsp_count", 64'(rspQ.size()), 64'(1));
      if (rspQ.size() > 0 && trnCyc.size() > 0) begin
         checkOutput("stall_rdt", 64'(rspQ[0].rdt), 64'(32'h11223344));
         checkOutput("stall_latency", 64'(rspCyc[0] - trnCyc[0]), 64'(DLY + 1));
      end

      // Reset with three responses buffered and one in flight.
      clearMon();
      rsp_rdy = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(vec_t'{1'b0, bpAdr[i], 4'hF, 32'h0, 32'h0, 1'b0});
      checkOutput("rstmid_busy_before", 64'(busy), 64'(1));
      cmd_vld = 1'b1;
      cmd_adr = 8'h10;
      rst     = 1'b1;
      #1;
      checkOutput("rstmid_rsp_vld", 64'(rsp_vld), 64'(0));
      checkOutput("rstmid_busy", 64'(busy), 64'(0));
      checkOutput("rstmid_cmd_rdy", 64'(cmd_rdy), 64'(0));
      checkOutput("rstmid_bus_vld", 64'(bus.vld), 64'(0));
      waitCycles(2);
      cmd_vld = 1'b0;
      rst     = 1'b0;
      clearMon();
      rsp_rdy = 1'b1;
      waitCycles(6);
      checkOutput("rstmid_no_stale", 64'(rspQ.size()), 64'(0));
      applyStimulus(vec_t'{1'b0, 8'h08, 4'hF, 32'h0, 32'h0, 1'b0});
      waitCycles(4);
      checkOutput("rstmid_new_count", 64'(rspQ.size()), 64'(1));
      if (rspQ.size() > 0) begin
         checkOutput("rstmid_new_rdt", 64'(rspQ[0].rdt), 64'(32'hA5A5FFFF));
         checkOutput("rstmid_new_wen", 64'(rspQ[0].wen), 64'(0));
         checkOutput("rstmid_new_err", 64'(rspQ[0].err), 64'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
